// File: rtl/home_cell_read_ctrl.sv
// Read sequencer for the home-cell position RAM: walks addresses once per phase, two phases
// per reference batch, and emits phase/broadcast_done/ref flags aligned to the RAM read data.
module home_cell_read_ctrl #(
    parameter int NUM_NEIGHBOR_CELLS = 13,
    parameter int NUM_FILTER         = 7,
    parameter int PARTICLE_ID_WIDTH  = 7
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start,
    input  logic [PARTICLE_ID_WIDTH-1:0]                         ref_home_id,
    input  logic [(NUM_NEIGHBOR_CELLS+1)*PARTICLE_ID_WIDTH-1:0]  iter_limit,
    input  logic                                                 pause_reading,
    output logic [PARTICLE_ID_WIDTH-1:0]                         rd_addr,
    output logic                                                 rd_en,
    output logic                                                 phase,
    output logic [NUM_NEIGHBOR_CELLS:0]                          broadcast_done,
    output logic                                                 ref_not_read_yet,
    output logic                                                 busy,
    output logic                                                 iter_done
);

    // state | meaning
    // IDLE  | waiting for start, inputs not sampled
    // PH0   | reading addresses for filter slots 0..NUM_FILTER-1
    // PH1   | reading addresses for filter slots NUM_FILTER..2*NUM_FILTER-1
    // DRAIN | last aligned data on the outputs, iter_done pulses

    localparam int W         = PARTICLE_ID_WIDTH;
    localparam int NUM_SLOTS = NUM_NEIGHBOR_CELLS + 1;
    localparam logic [W-1:0] ADDR_ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PH0   = 2'd1,
        PH1   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t         state;
    logic [W-1:0]   limit_q [NUM_SLOTS];
    logic [W-1:0]   len0_q;
    logic [W-1:0]   len1_q;
    logic [W-1:0]   ref_id_q;

    logic [W-1:0]   len0_in;
    logic [W-1:0]   len1_in;
    logic [W-1:0]   cur_len;
    logic           last_read;
    logic [NUM_SLOTS-1:0] bd_next;

    // Phase lengths from the live inputs; only consumed on the start edge.
    always_comb begin
        len0_in = '0;
        len1_in = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (k < NUM_FILTER) begin
                if (iter_limit[k*W +: W] > len0_in)
                    len0_in = iter_limit[k*W +: W];
            end else begin
                if (iter_limit[k*W +: W] > len1_in)
                    len1_in = iter_limit[k*W +: W];
            end
        end
    end

    assign rd_en     = ((state == PH0) || (state == PH1)) && !pause_reading;
    assign cur_len   = (state == PH0) ? len0_q : len1_q;
    assign last_read = rd_en && (rd_addr == (cur_len - ADDR_ONE));

    // Slots of the inactive phase always report done.
    always_comb begin
        bd_next = '1;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if ((k < NUM_FILTER) == (state == PH0))
                bd_next[k] = (rd_addr >= limit_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rd_addr          <= '0;
            phase            <= 1'b0;
            broadcast_done   <= '1;
            ref_not_read_yet <= 1'b0;
            busy             <= 1'b0;
            iter_done        <= 1'b0;
            len0_q           <= '0;
            len1_q           <= '0;
            ref_id_q         <= '0;
            for (int k = 0; k < NUM_SLOTS; k++)
                limit_q[k] <= '0;
        end else begin
            iter_done <= 1'b0;

            if (rd_en) begin
                phase            <= (state == PH1);
                broadcast_done   <= bd_next;
                ref_not_read_yet <= (state == PH0) && (rd_addr <= ref_id_q);
            end else begin
                broadcast_done   <= '1;
                ref_not_read_yet <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len0_q   <= len0_in;
                        len1_q   <= len1_in;
                        ref_id_q <= ref_home_id;
                        for (int k = 0; k < NUM_SLOTS; k++)
                            limit_q[k] <= iter_limit[k*W +: W];
                        rd_addr <= '0;
                        busy    <= 1'b1;
                        if (len0_in != '0) begin
                            state <= PH0;
                        end else if (len1_in != '0) begin
                            state <= PH1;
                        end else begin
                            state     <= DRAIN;
                            iter_done <= 1'b1;
                        end
                    end
                end
                PH0: begin
                    if (last_read) begin
                        rd_addr <= '0;
                        if (len1_q != '0) begin
                            state <= PH1;
                        end else begin
                            state     <= DRAIN;
                            iter_done <= 1'b1;
                        end
                    end else if (rd_en) begin
                        rd_addr <= rd_addr + ADDR_ONE;
                    end
                end
                PH1: begin
                    if (last_read) begin
                        rd_addr   <= '0;
                        state     <= DRAIN;
                        iter_done <= 1'b1;
                    end else if (rd_en) begin
                        rd_addr <= rd_addr + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_home_cell_read_ctrl.sv
// Scoreboard bench for home_cell_read_ctrl: each scenario queues per-cycle expectations,
// drives one batch, and a negedge monitor pops and compares them.
module tb_home_cell_read_ctrl;

    localparam int W  = 7;
    localparam int NS = 14;

    logic              clk;
    logic              rst;
    logic              start;
    logic [W-1:0]      ref_home_id;
    logic [NS*W-1:0]   iter_limit;
    logic              pause_reading;
    logic [W-1:0]      rd_addr;
    logic              rd_en;
    logic              phase;
    logic [NS-1:0]     broadcast_done;
    logic              ref_not_read_yet;
    logic              busy;
    logic              iter_done;

    home_cell_read_ctrl #(
        .NUM_NEIGHBOR_CELLS(13),
        .NUM_FILTER(7),
        .PARTICLE_ID_WIDTH(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ref_home_id(ref_home_id),
        .iter_limit(iter_limit),
        .pause_reading(pause_reading),
        .rd_addr(rd_addr),
        .rd_en(rd_en),
        .phase(phase),
        .broadcast_done(broadcast_done),
        .ref_not_read_yet(ref_not_read_yet),
        .busy(busy),
        .iter_done(iter_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {F_RDEN, F_ADDR, F_PHASE, F_BD, F_RNRY, F_BUSY, F_IDONE} field_t;
    typedef struct {
        int          cyc;
        field_t      fld;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cur_cyc  = 0;
    bit   tracking = 1'b0;

    function automatic logic [31:0] observe(field_t f);
        case (f)
            F_RDEN:  return {31'd0, rd_en};
            F_ADDR:  return {25'd0, rd_addr};
            F_PHASE: return {31'd0, phase};
            F_BD:    return {18'd0, broadcast_done};
            F_RNRY:  return {31'd0, ref_not_read_yet};
            F_BUSY:  return {31'd0, busy};
            default: return {31'd0, iter_done};
        endcase
    endfunction

    // Insert keeping the queue ordered by cycle.
    task automatic ex(input int c, input field_t f, input logic [31:0] v);
        exp_t e;
        int   pos;
        e.cyc = c;
        e.fld = f;
        e.exp = v;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (tracking) begin
            while (sb.size() > 0 && sb[0].cyc == cur_cyc) begin
                e   = sb.pop_front();
                act = observe(e.fld);
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s @c%0d: got %0h expected %0h", e.fld.name(), cur_cyc, act, e.exp);
                end
            end
        end
    end

    task automatic set_limits(input int lim [NS], input int ref_id);
        for (int k = 0; k < NS; k++)
            iter_limit[k*W +: W] = W'(lim[k]);
        ref_home_id = W'(ref_id);
    endtask

    // Drives one batch: start at c0, optional second start and reset; inputs are scrambled
    // at c1 so any mid-batch re-sampling shows up in the aligned outputs.
    task automatic run_batch(input int n, input logic [31:0] pmask, input int start2, input int rstc);
        @(posedge clk);
        #1;
        cur_cyc       = 0;
        tracking      = 1'b1;
        start         = 1'b1;
        pause_reading = pmask[0];
        rst           = 1'b0;
        for (int c = 1; c < n; c++) begin
            @(posedge clk);
            #1;
            cur_cyc       = c;
            start         = (c == start2);
            pause_reading = pmask[c];
            rst           = (c == rstc);
            if (c == 1) begin
                iter_limit  = {$urandom, $urandom, $urandom, $urandom};
                ref_home_id = W'($urandom);
            end
        end
        @(negedge clk);
        #1;
        tracking      = 1'b0;
        start         = 1'b0;
        pause_reading = 1'b0;
        rst           = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d unconsumed expectations, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rd_addr, rd_en, phase, ref_not_read_yet, busy, iter_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %0h expected 0",
                     {rd_addr, rd_en, phase, ref_not_read_yet, busy, iter_done});
        end
        n_checks++;
        if (broadcast_done !== '1) begin
            n_fail++;
            $display("FAIL reset_bd: got %0h expected 3fff", broadcast_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lim [NS];
        for (int k = 0; k < NS; k++) lim[k] = 3;
        set_limits(lim, 1);
        ex(0, F_BUSY, 0);
        ex(0, F_RDEN, 0);
        ex(1, F_BD, 32'h3FFF);
        for (int c = 1; c <= 6; c++) begin
            ex(c, F_RDEN, 1);
            ex(c, F_ADDR, 32'((c - 1) % 3));
            ex(c, F_BUSY, 1);
            ex(c, F_IDONE, 0);
        end
        for (int c = 2; c <= 4; c++) begin
            ex(c, F_PHASE, 0);
            ex(c, F_BD, 32'h3F80);
        end
        for (int c = 5; c <= 7; c++) begin
            ex(c, F_PHASE, 1);
            ex(c, F_BD, 32'h007F);
        end
        ex(2, F_RNRY, 1);
        ex(3, F_RNRY, 1);
        ex(4, F_RNRY, 0);
        ex(5, F_RNRY, 0);
        ex(7, F_IDONE, 1);
        ex(7, F_BUSY, 1);
        ex(7, F_RDEN, 0);
        ex(8, F_IDONE, 0);
        ex(8, F_BUSY, 0);
        ex(8, F_RDEN, 0);
        ex(8, F_BD, 32'h3FFF);
        run_batch(9, 32'h0, -1, -1);
    endtask

    task automatic test_broadcast_mask();
        int lim [NS];
        for (int k = 0; k < NS; k++) lim[k] = (k < 7) ? 4 : 0;
        lim[3] = 1;
        set_limits(lim, 0);
        ex(1, F_BD, 32'h3FFF);
        ex(2, F_BD, 32'h3F80);
        ex(2, F_PHASE, 0);
        ex(2, F_RNRY, 1);
        ex(3, F_RNRY, 0);
        for (int c = 3; c <= 5; c++) ex(c, F_BD, 32'h3F88);
        for (int c = 1; c <= 4; c++) ex(c, F_ADDR, 32'(c - 1));
        ex(4, F_IDONE, 0);
        ex(5, F_IDONE, 1);
        ex(5, F_RDEN, 0);
        ex(6, F_BD, 32'h3FFF);
        ex(6, F_BUSY, 0);
        run_batch(7, 32'h0, -1, -1);
    endtask

    task automatic test_pause();
        int lim [NS];
        int addrs [10] = '{0, 0, 1, 1, 1, 2, 0, 1, 2, 0};
        for (int k = 0; k < NS; k++) lim[k] = 3;
        set_limits(lim, 1);
        for (int c = 1; c <= 8; c++) begin
            ex(c, F_ADDR, 32'(addrs[c]));
            ex(c, F_RDEN, (c == 2 || c == 3) ? 0 : 1);
        end
        ex(2, F_BD, 32'h3F80);
        ex(2, F_RNRY, 1);
        ex(3, F_BD, 32'h3FFF);
        ex(3, F_RNRY, 0);
        ex(4, F_BD, 32'h3FFF);
        ex(4, F_RNRY, 0);
        ex(5, F_BD, 32'h3F80);
        ex(5, F_RNRY, 1);
        ex(6, F_RNRY, 0);
        ex(7, F_PHASE, 1);
        ex(8, F_IDONE, 0);
        ex(9, F_IDONE, 1);
        ex(9, F_RDEN, 0);
        ex(10, F_IDONE, 0);
        run_batch(11, 32'h0000_000C, -1, -1);
    endtask

    task automatic test_phase1_only();
        int lim [NS];
        for (int k = 0; k < NS; k++) lim[k] = 0;
        lim[8] = 2;
        set_limits(lim, 5);
        ex(1, F_RDEN, 1);
        ex(1, F_ADDR, 0);
        ex(2, F_RDEN, 1);
        ex(2, F_ADDR, 1);
        ex(2, F_PHASE, 1);
        ex(2, F_BD, 32'h3EFF);
        ex(2, F_RNRY, 0);
        ex(3, F_PHASE, 1);
        ex(3, F_BD, 32'h3EFF);
        ex(3, F_IDONE, 1);
        ex(3, F_RDEN, 0);
        ex(4, F_BD, 32'h3FFF);
        ex(4, F_BUSY, 0);
        run_batch(5, 32'h0, -1, -1);
    endtask

    task automatic test_all_zero();
        int lim [NS];
        for (int k = 0; k < NS; k++) lim[k] = 0;
        set_limits(lim, 0);
        for (int c = 0; c <= 3; c++) ex(c, F_RDEN, 0);
        ex(1, F_IDONE, 1);
        ex(1, F_BUSY, 1);
        ex(2, F_IDONE, 0);
        ex(2, F_BUSY, 0);
        run_batch(4, 32'h0, -1, -1);
    endtask

    task automatic test_reset_mid_batch();
        int lim [NS];
        for (int k = 0; k < NS; k++) lim[k] = 3;
        set_limits(lim, 1);
        ex(2, F_ADDR, 1);
        ex(2, F_BUSY, 1);
        ex(3, F_ADDR, 2);
        ex(4, F_RDEN, 1);
        ex(4, F_ADDR, 0);
        ex(5, F_ADDR, 0);
        ex(5, F_RDEN, 0);
        ex(5, F_PHASE, 0);
        ex(5, F_BD, 32'h3FFF);
        ex(5, F_RNRY, 0);
        ex(5, F_BUSY, 0);
        for (int c = 5; c <= 10; c++) begin
            ex(c, F_IDONE, 0);
            ex(c, F_RDEN, 0);
        end
        run_batch(11, 32'h0, 2, 4);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        pause_reading = 1'b0;
        ref_home_id   = '0;
        iter_limit    = '0;
        test_reset();
        test_basic();
        test_broadcast_mask();
        test_pause();
        test_phase1_only();
        test_all_zero();
        test_reset_mid_batch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected end of test");
        $fatal(1);
    end

endmodule
